wb_write_arbiter: RTL and testbench

- Writer side of the register-file write port (reg_write / rd / write_data).
- Merges two writeback sources into one registered write per cycle:
  - the single-cycle ALU/load path;
  - a long-latency multiply/divide unit (MDU), whose results are buffered in a small FIFO.
- Keeps a per-register busy scoreboard of outstanding MDU destinations for the hazard unit.
- Sits between the MEM/WB pipeline register and the register file.

---
 rtl/wb_write_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the ALU path and a FIFO of MDU results into one
// registered register-file write per cycle, and tracks outstanding MDU destinations.
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      mdu_valid,
  input  logic [ADDR_W-1:0]         mdu_rd,
  input  logic [DATA_W-1:0]         mdu_data,
  output logic                      mdu_ready,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         write_data,
  output logic [(1<<ADDR_W)-1:0]    busy,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] fifo_rd_mem   [DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              full;
  logic              empty;
  logic              enq;
  logic              deq;
  logic              alu_win;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    alu_ready = !full;
    mdu_ready = !full;
    head_rd   = fifo_rd_mem[rd_ptr_q];
    head_data = fifo_data_mem[rd_ptr_q];
    // rd==0 MDU results are handshaken but never stored
    enq       = mdu_valid && !full && (mdu_rd != '0);
    deq       = !empty && (full || !alu_valid);
    alu_win   = alu_valid && !full;
  end

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    unique case (1'b1)
      deq: begin
        reg_write_d = 1'b1;
        rd_d        = head_rd;
        data_d      = head_data;
      end
      alu_win: begin
        if (alu_rd != '0) begin
          reg_write_d = 1'b1;
          rd_d        = alu_rd;
          data_d      = alu_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (deq)
      busy_d[head_rd] = 1'b0;
    // a new issue to the same register outranks the retiring clear
    if (issue_valid && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_mem[wr_ptr_q]   <= mdu_rd;
      fifo_data_mem[wr_ptr_q] <= mdu_data;
    end
  end

  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = data_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: directed stimulus pushes expected
// writes, a monitor pops them whenever reg_write is seen.
module tb_wb_write_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        clr;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] busy;
  logic [2:0]  fifo_count;

  wr_t exp_q[$];
  int  errors;
  int  checks;
  int  n;
  int  cyc;
  logic [31:0] stall;
  logic [31:0] gap;

  wb_write_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .clr(clr),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    wr_t e;
    #1;
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h expected none",
                 rd, write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_rd", 64'(rd), 64'(e.rd));
        chk("wr_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    mdu_valid   = 1'b0;
    mdu_rd      = '0;
    mdu_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // reset state
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_data", 64'(write_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_mdu_ready", 64'(mdu_ready), 64'd1);

    // 1: single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    exp_q.push_back('{5'd5, 32'h1234});
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("t1_idle_reg_write", 64'(reg_write), 64'd0);

    // 2: issue then MDU result
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    idle();
    chk("t2_busy_set", 64'(busy[7]), 64'd1);
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEAD;
    exp_q.push_back('{5'd7, 32'hDEAD});
    @(negedge clk);
    idle();
    chk("t2_count1", 64'(fifo_count), 64'd1);
    chk("t2_busy_held", 64'(busy[7]), 64'd1);
    @(negedge clk);
    chk("t2_write", 64'(reg_write), 64'd1);
    chk("t2_busy_clr", 64'(busy[7]), 64'd0);
    chk("t2_count0", 64'(fifo_count), 64'd0);

    // 3: ALU streaming while the FIFO fills
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000_0000 + i;
      mdu_valid = 1'b1; mdu_rd = 5'(1 + i);  mdu_data = 32'hB000_0000 + i;
      exp_q.push_back('{5'(10 + i), 32'hA000_0000 + i});
      @(negedge clk);
    end
    exp_q.push_back('{5'd1, 32'hB000_0000});
    exp_q.push_back('{5'd14, 32'hA000_0014});
    exp_q.push_back('{5'd2, 32'hB000_0001});
    exp_q.push_back('{5'd3, 32'hB000_0002});
    exp_q.push_back('{5'd4, 32'hB000_0003});
    mdu_valid = 1'b0;
    alu_rd = 5'd14; alu_data = 32'hA000_0014;
    #1;
    chk("t3_count_full", 64'(fifo_count), 64'd4);
    chk("t3_mdu_ready", 64'(mdu_ready), 64'd0);
    chk("t3_alu_blocked", 64'(alu_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("t3_alu_ready_back", 64'(alu_ready), 64'd1);
    chk("t3_count3", 64'(fifo_count), 64'd3);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    chk("t3_drained", 64'(fifo_count), 64'd0);

    // 4: wrap-around with ALU rd=0 stalls blocking the drain
    stall = 32'h0000_F03F;
    gap   = 32'h0000_0240;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 64) begin
      alu_valid = stall[cyc];
      alu_rd    = 5'd0;
      alu_data  = 32'(cyc);
      mdu_valid = !gap[cyc];
      mdu_rd    = 5'(16 + n);
      mdu_data  = 32'hC0DE_0000 + n;
      #1;
      chk("t4_count_bound", 64'(fifo_count <= 3'd4), 64'd1);
      if (mdu_valid && mdu_ready) begin
        exp_q.push_back('{5'(16 + n), 32'hC0DE_0000 + n});
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("t4_all_enqueued", 64'(n), 64'd10);
    idle();
    repeat (6) @(negedge clk);
    chk("t4_drained", 64'(fifo_count), 64'd0);

    // 5: rd=0 handling
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    #1;
    chk("t5_alu0_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    idle();
    chk("t5_alu0_no_write", 64'(reg_write), 64'd0);
    chk("t5_alu0_rd_hold", 64'(rd), 64'd25);
    chk("t5_alu0_data_hold", 64'(write_data), 64'hC0DE_0009);
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h5555;
    #1;
    chk("t5_mdu0_ready", 64'(mdu_ready), 64'd1);
    @(negedge clk);
    idle();
    chk("t5_mdu0_count", 64'(fifo_count), 64'd0);
    @(negedge clk);
    chk("t5_mdu0_no_write", 64'(reg_write), 64'd0);
    issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    chk("t5_busy3", 64'(busy), 64'h8);
    issue_rd = 5'd0;
    @(negedge clk);
    idle();
    chk("t5_issue0", 64'(busy), 64'h8);
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
    exp_q.push_back('{5'd3, 32'h33});
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    chk("t5_busy_cleared", 64'(busy), 64'h0);

    // 6: reset with entries queued and busy bits set
    for (int i = 0; i < 3; i++) begin
      alu_valid   = 1'b1; alu_rd = 5'd0;
      issue_valid = 1'b1;
      mdu_valid   = 1'b1;
      issue_rd    = (i == 2) ? 5'd7 : 5'(i + 1);
      mdu_rd      = issue_rd;
      mdu_data    = 32'hEE00 + i;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    mdu_valid   = 1'b0;
    chk("t6_count3", 64'(fifo_count), 64'd3);
    chk("t6_busy86", 64'(busy), 64'h86);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle();
    chk("t6_count_rst", 64'(fifo_count), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_reg_write_rst", 64'(reg_write), 64'd0);
    repeat (6) @(negedge clk);
    chk("t6_count_stays", 64'(fifo_count), 64'd0);
    chk("t6_busy_stays", 64'(busy), 64'd0);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
